// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared state encoding, reset-default config and length clamp for the pattern detector.
package seq_detect_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2,
    DONE = 2'd3
  } state_t;
  localparam logic DEF_OVERLAP = 1'b1;
  localparam int   DEF_LIMIT   = 0;
  localparam int   DEF_PATTERN = 0;
  // zero means one bit; anything longer than the window is cut to the window
  function automatic int clamp_len(int len, int max_len);
    return (len == 0) ? 1 : ((len > max_len) ? max_len : len);
  endfunction
endpackage

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: serial input, configuration, control and status bundle for seq_detect_ctrl.
interface seq_detect_ctrl_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = 3
);
  logic             in;
  logic             in_valid;
  logic             cfg_we;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_limit;
  logic             arm;
  logic             disarm;
  logic             irq_ack;
  logic             match;
  logic             irq;
  logic             busy;
  logic [CNT_W-1:0] match_cnt;
  modport master (
    output in, in_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_limit, arm, disarm, irq_ack,
    input  match, irq, busy, match_cnt
  );
  modport slave (
    input  in, in_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_limit, arm, disarm, irq_ack,
    output match, irq, busy, match_cnt
  );
endinterface

// File: rtl/seq_shift_cmp.sv
// seq_shift_cmp: bit window, fill counter and length-masked pattern compare.
module seq_shift_cmp #(
  parameter int PAT_W = 4,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             en,
  input  logic             clr,
  input  logic             clr_fill,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             match_now,
  output logic             full_now
);
  logic [PAT_W-1:0] win_q, win_d, win_new, mask;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [LEN_W:0]   fill_inc;
  logic             take;
  always_comb begin
    take      = en && in_valid;
    win_new   = PAT_W'({win_q, in_bit});
    mask      = {PAT_W{1'b1}} >> (PAT_W - int'(len));
    fill_inc  = {1'b0, fill_q} + (LEN_W+1)'(1);
    // the bit being accepted completes the history, so it is compared on this edge
    full_now  = take && (fill_inc >= {1'b0, len});
    match_now = full_now && (((win_new ^ pattern) & mask) == '0);
    win_d     = clr ? '0 : (take ? win_new : win_q);
    fill_d    = clr ? '0 :
                !take ? fill_q :
                clr_fill ? '0 :
                (fill_q < len) ? fill_inc[LEN_W-1:0] : fill_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial-pattern detector with arm/disarm, match counting and limit irq.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = 3
) (
  input logic              clk,
  input logic              reset,
  seq_detect_ctrl_if.slave bus
);
  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             irq_q, irq_d;
  logic             match_q, match_d;
  logic             en, clr, clr_fill, match_now, full_now;
  seq_shift_cmp #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .in_bit   (bus.in),
    .in_valid (bus.in_valid),
    .en       (en),
    .clr      (clr),
    .clr_fill (clr_fill),
    .pattern  (pat_q),
    .len      (len_q),
    .match_now(match_now),
    .full_now (full_now)
  );
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    irq_d    = irq_q;
    match_d  = 1'b0;
    clr      = 1'b0;
    clr_fill = 1'b0;
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    en       = (state_q == FILL || state_q == HUNT) && !bus.disarm;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    lim_d    = lim_q;
    if (state_q == IDLE && bus.cfg_we) begin
      pat_d = bus.cfg_pattern;
      len_d = LEN_W'(clamp_len(int'(bus.cfg_len), PAT_W));
      ovl_d = bus.cfg_overlap;
      lim_d = bus.cfg_limit;
    end
    if (bus.disarm) begin
      state_d = IDLE;
      irq_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.arm) begin
          state_d = FILL;
          clr     = 1'b1;
          cnt_d   = '0;
          irq_d   = 1'b0;
        end
        FILL, HUNT: if (match_now) begin
          match_d = 1'b1;
          cnt_d   = cnt_inc;
          // reaching the limit wins over the non-overlap refill
          if (lim_q != '0 && cnt_inc >= lim_q) begin
            state_d = DONE;
            irq_d   = 1'b1;
          end else if (!ovl_q) begin
            state_d  = FILL;
            clr_fill = 1'b1;
          end else state_d = HUNT;
        end else if (full_now) state_d = HUNT;
        DONE: if (bus.irq_ack) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= PAT_W'(DEF_PATTERN);
      len_q   <= LEN_W'(PAT_W);
      ovl_q   <= DEF_OVERLAP;
      lim_q   <= CNT_W'(DEF_LIMIT);
      cnt_q   <= '0;
      irq_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      lim_q   <= lim_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      match_q <= match_d;
    end
  end
  assign bus.match     = match_q;
  assign bus.irq       = irq_q;
  assign bus.busy      = (state_q == FILL) || (state_q == HUNT);
  assign bus.match_cnt = cnt_q;
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial-pattern detection controller. It owns the bit-window datapath and sequences it: it loads the pattern and length, arms and disarms detection, counts matches and raises an interrupt when a match limit is reached. It sits between a serial bit source and a host/control FSM, replacing fixed-pattern detectors with one configurable, handshaked block.

Parameters:
PAT_W, 4, maximum pattern length in bits
CNT_W, 8, match counter / limit width
LEN_W, 3, width of cfg_len; must equal $clog2(PAT_W+1)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high reset
in  in  1  serial data bit
in_valid  in  1  in is sampled on this edge only when high
cfg_we  in  1  load cfg_* registers; honoured only in IDLE
cfg_pattern  in  PAT_W  pattern; bit[len-1] is the first bit received, bit0 the last
cfg_len  in  LEN_W  active pattern length
cfg_overlap  in  1  1 = overlapping matches, 0 = history cleared after a match
cfg_limit  in  CNT_W  stop after this many matches; 0 = unlimited
arm  in  1  start detection (IDLE only)
disarm  in  1  abort to IDLE from any state
irq_ack  in  1  acknowledge irq in DONE
match  out  1  one-cycle registered pulse per match
irq  out  1  level; high in DONE until acked or disarmed
busy  out  1  high in FILL or HUNT
match_cnt  out  CNT_W  matches since the last arm, saturating

Behaviour:
- Reset (async): state=IDLE; match, irq, busy, match_cnt = 0; window and fill count = 0; pattern = 0, len = PAT_W, overlap = 1, limit = 0.
- Length rule: cfg_len=0 is stored as 1. cfg_len>PAT_W is stored as PAT_W. Compare uses only the low len bits of the window and pattern.
- Window: shift register; each accepted bit enters at bit0. fill = number of valid history bits, saturating at len.
- States (package enum): IDLE, FILL, HUNT, DONE.
- IDLE: input is ignored and cfg_we loads. arm with no disarm goes to FILL and clears window, fill, match_cnt and irq.
- FILL: an accepted bit shifts in and fill increments. When fill reaches len on a bit, go to HUNT and evaluate that bit.
- HUNT: every accepted bit is compared against the window including that new bit.
- On a match at the accepting edge:
  - match=1 for the following cycle; match_cnt increments, saturating at all-ones.
  - overlap=0: fill is cleared and the state returns to FILL.
  - If limit≠0 and the new count is ≥ limit: go to DONE and set irq. This takes priority over the FILL return.
- Latency: match and irq are high in the cycle after the edge that accepts the final pattern bit.
- DONE: input is ignored and busy=0. irq_ack sets irq=0 and the state to IDLE on the next edge. match_cnt holds.
- disarm: in any state, next state IDLE and irq=0; match_cnt holds.
- Priorities: disarm > arm; disarm > irq_ack.
- Ignored inputs:
  - arm outside IDLE.
  - cfg_we outside IDLE.
  - irq_ack outside DONE.
  - in_valid=0 cycles: no shift and no compare.
- cfg_we and arm in the same IDLE cycle: the new config is loaded and used by that arm.

Decomposition:
- Package seq_detect_pkg holds the state enum (IDLE=0, FILL=1, HUNT=2, DONE=3) and the default-config constants.
- Sub-module seq_shift_cmp holds the window shift register, fill counter and length-masked compare. Its output match_now is combinational, qualified by in_valid and fill.
- The top level holds the FSM, config registers, counter and irq.

Test Plan:
1. PAT_W=4, pattern 4'b1011, len 4, overlap 1, limit 0, arm; send 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7; match_cnt=2; busy=1 throughout.
2. Same setup with overlap 0 and the same stream -> single match after bit 4; match_cnt=1; state FILL at the end.
3. Pattern 2'b11, len 2, overlap 1, limit 2; send 1,1,1,1 -> matches after bits 2 and 3, then DONE with irq=1 and busy=0; bit 4 is ignored and match_cnt=2. Pulse irq_ack -> irq=0 and IDLE next cycle.
4. Armed, FILL with 2 bits in; assert reset between edges -> all outputs 0 immediately; len reads back as the default 4.
5. Boundaries:
   - arm and disarm in the same cycle -> stays IDLE.
   - cfg_we while busy -> pattern unchanged.
   - in_valid=0 gaps between bits -> same result as scenario 1.
   - 300 matches with limit 0 -> match_cnt=255.
6. cfg_len=0, pattern bit0=1, overlap 0; send 1,0,1 -> 2 matches (treated as len 1).
